// File: rtl/pwm_duty_ramp.sv
// Slew-limited duty controller feeding pwm_module: accepts a clamped target and
// walks duty toward it in programmable steps, changing only on PWM period boundaries.
module pwm_duty_ramp #(
  parameter int bit_width      = 10,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [bit_width-1:0]      target_duty,
  input  logic                      target_valid,
  output logic                      target_ready,
  input  logic [bit_width-1:0]      max_value,
  input  logic [bit_width-1:0]      step,
  input  logic [PRESCALE_WIDTH-1:0] periods_per_step,
  output logic [bit_width-1:0]      duty,
  output logic                      period_tick,
  output logic                      busy
);

  localparam int W1 = bit_width + 1;

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  state_t                    state, state_nxt;
  logic                      run;
  logic [bit_width-1:0]      cnt;
  logic [bit_width-1:0]      tgt, tgt_nxt;
  logic [bit_width-1:0]      duty_r, duty_nxt;
  logic [PRESCALE_WIDTH-1:0] pcnt, pcnt_nxt;
  logic [bit_width-1:0]      tgt_clamped;
  logic                      boundary;
  logic                      accept;

  // Saturate a request to max_value+1 (100% duty). The result never exceeds
  // the request itself, so it always fits in bit_width bits.
  function automatic logic [bit_width-1:0] clamp_target(
    input logic [bit_width-1:0] req,
    input logic [bit_width-1:0] top
  );
    logic [bit_width:0] lim;
    logic [bit_width:0] req_w;
    lim   = {1'b0, top} + W1'(1);
    req_w = {1'b0, req};
    if (req_w > lim) return lim[bit_width-1:0];
    return req;
  endfunction

  // One slew step toward the target; lands exactly on it when within reach,
  // so the result always lies between cur and tgt (no wrap, no overshoot).
  function automatic logic [bit_width-1:0] step_toward(
    input logic [bit_width-1:0] cur,
    input logic [bit_width-1:0] dst,
    input logic [bit_width-1:0] step_sz
  );
    logic [bit_width:0] c, t, s, d, r;
    c = {1'b0, cur};
    t = {1'b0, dst};
    s = (step_sz == '0) ? W1'(1) : {1'b0, step_sz};
    d = (t >= c) ? (t - c) : (c - t);
    if (d <= s)     r = t;
    else if (t > c) r = c + s;
    else            r = c - s;
    return r[bit_width-1:0];
  endfunction

  assign boundary     = (cnt >= max_value);
  assign target_ready = (state == IDLE) && run;
  assign busy         = (state == RAMP);
  assign accept       = target_ready && target_valid;
  assign tgt_clamped  = clamp_target(target_duty, max_value);
  assign duty         = duty_r;

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    duty_nxt  = duty_r;
    pcnt_nxt  = pcnt;
    case (state)
      IDLE: begin
        if (accept) begin
          tgt_nxt  = tgt_clamped;
          pcnt_nxt = '0;
          if (tgt_clamped != duty_r) state_nxt = RAMP;
        end
      end
      RAMP: begin
        if (boundary) begin
          if (pcnt != periods_per_step) begin
            pcnt_nxt = pcnt + PRESCALE_WIDTH'(1);
          end else begin
            pcnt_nxt = '0;
            duty_nxt = step_toward(duty_r, tgt, step);
            if (duty_nxt == tgt) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // run holds target_ready low through reset and for the release edge itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      run         <= 1'b0;
      cnt         <= '0;
      pcnt        <= '0;
      period_tick <= 1'b0;
      duty_r      <= '0;
    end else begin
      state       <= state_nxt;
      run         <= 1'b1;
      cnt         <= boundary ? '0 : cnt + bit_width'(1);
      pcnt        <= pcnt_nxt;
      period_tick <= boundary;
      duty_r      <= duty_nxt;
    end
  end

  always_ff @(posedge clk) begin
    tgt <= tgt_nxt;
  end

endmodule
